// File: rtl/lcd_timing_pkg.sv
// Shared timing constants and colour values for the 800x480 RGB565 panel.
// Renderers import the same colours for their backgrounds.
package lcd_timing_pkg;

  localparam int LCD_H_SYNC   = 1;
  localparam int LCD_H_BP     = 182;
  localparam int LCD_H_ACTIVE = 800;
  localparam int LCD_H_FP     = 210;
  localparam int LCD_V_SYNC   = 5;
  localparam int LCD_V_BP     = 0;
  localparam int LCD_V_ACTIVE = 480;
  localparam int LCD_V_FP     = 45;
  localparam int LCD_PIPE_LAT = 1;

  // 16-bit {R[4:0], G[5:0], B[4:0]}
  localparam logic [15:0] COLOR_WHITE   = 16'hFFFF;
  localparam logic [15:0] COLOR_BLACK   = 16'h0000;
  localparam logic [15:0] COLOR_RED     = 16'hF800;
  localparam logic [15:0] COLOR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COLOR_CYAN    = 16'h07FF;
  localparam logic [15:0] COLOR_GREEN   = 16'h07E0;
  localparam logic [15:0] COLOR_MAGENTA = 16'hF81F;
  localparam logic [15:0] COLOR_BLUE    = 16'h001F;

  typedef enum logic [1:0] {PH_SYNC, PH_BP, PH_ACTIVE, PH_FP} phase_t;

  // Decode a counter value into its phase; zero-length phases never match.
  function automatic phase_t phase_of(input logic [15:0] cnt, input int sync_len,
                                      input int bp_len, input int act_len);
    int c;
    c = int'(cnt);
    if (c < sync_len)                       return PH_SYNC;
    else if (c < sync_len + bp_len)         return PH_BP;
    else if (c < sync_len + bp_len + act_len) return PH_ACTIVE;
    else                                    return PH_FP;
  endfunction

  // Colour-bar order, left to right.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return COLOR_WHITE;
      3'd1:    return COLOR_YELLOW;
      3'd2:    return COLOR_CYAN;
      3'd3:    return COLOR_GREEN;
      3'd4:    return COLOR_MAGENTA;
      3'd5:    return COLOR_RED;
      3'd6:    return COLOR_BLUE;
      default: return COLOR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Coordinate/colour/panel bundle around lcd_timing_gen. The timing generator
// keeps its legacy panel pin names; this bundle is how renderers and the
// panel side see those same wires. master = timing generator, slave = the
// renderer/panel side.
interface lcd_timing_gen_if;
  import lcd_timing_pkg::*;

  logic [15:0] pixel_count;
  logic [15:0] line_count;
  logic        line_start;
  logic        frame_start;
  logic [4:0]  rgb_r;
  logic [5:0]  rgb_g;
  logic [4:0]  rgb_b;
  logic        den;
  logic        hsync;
  logic        vsync;
  logic [4:0]  r;
  logic [5:0]  g;
  logic [4:0]  b;

  modport master (
    output pixel_count, line_count, line_start, frame_start,
    input  rgb_r, rgb_g, rgb_b,
    output den, hsync, vsync, r, g, b
  );

  modport slave (
    input  pixel_count, line_count, line_start, frame_start,
    output rgb_r, rgb_g, rgb_b,
    input  den, hsync, vsync, r, g, b
  );

endinterface

// File: rtl/lcd_timing_gen_sync_delay_line.sv
// sync_delay_line: WIDTH x DEPTH shift register, async reset to RESET_VAL.
// DEPTH=0 degenerates to a plain wire.
module sync_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift one stage per clock; reset loads every stage with RESET_VAL
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: timing master for the RGB565 LCD. Produces renderer
// coordinates, re-aligns the returned colour with DE/HSYNC/VSYNC across the
// renderer latency, and drives the panel pins.
// Optional build macro LCD_TEST_PATTERN_EN: replace rgb_in with 8 colour bars.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC   = LCD_H_SYNC,
  parameter int H_BP     = LCD_H_BP,
  parameter int H_ACTIVE = LCD_H_ACTIVE,
  parameter int H_FP     = LCD_H_FP,
  parameter int V_SYNC   = LCD_V_SYNC,
  parameter int V_BP     = LCD_V_BP,
  parameter int V_ACTIVE = LCD_V_ACTIVE,
  parameter int V_FP     = LCD_V_FP,
  parameter int PIPE_LAT = LCD_PIPE_LAT
) (
  input  logic        PixelClk,
  input  logic        nRST,
  output logic [15:0] PixelCount,
  output logic [15:0] LineCount,
  output logic        line_start,
  output logic        frame_start,
  input  logic [4:0]  rgb_in_R,
  input  logic [5:0]  rgb_in_G,
  input  logic [4:0]  rgb_in_B,
  output logic        LCD_DEN,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B
);

  localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int V_ACT_START = V_SYNC + V_BP;

  // run is low until the first edge after reset so that edge holds hcnt=0.
  logic        run;
  logic [15:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
  phase_t      h_ph, v_ph;
  logic        de_raw, hs_raw, vs_raw;
  logic [2:0]  ctrl_del;
  logic [15:0] pix;

  // Next counter values and the phases they fall in
  always_comb begin
    hcnt_nxt = hcnt;
    vcnt_nxt = vcnt;
    if (run) begin
      if (hcnt == 16'(H_TOTAL - 1)) begin
        hcnt_nxt = '0;
        vcnt_nxt = (vcnt == 16'(V_TOTAL - 1)) ? '0 : vcnt + 16'd1;
      end else begin
        hcnt_nxt = hcnt + 16'd1;
      end
    end
    h_ph = phase_of(hcnt_nxt, H_SYNC, H_BP, H_ACTIVE);
    v_ph = phase_of(vcnt_nxt, V_SYNC, V_BP, V_ACTIVE);
  end

  // Counters plus coordinate/raw-sync registers, all in the same cycle
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      run         <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      PixelCount  <= 16'(H_ACTIVE);
      LineCount   <= 16'(V_ACTIVE);
      de_raw      <= 1'b0;
      hs_raw      <= 1'b0;
      vs_raw      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      run         <= 1'b1;
      hcnt        <= hcnt_nxt;
      vcnt        <= vcnt_nxt;
      PixelCount  <= (h_ph == PH_ACTIVE) ? hcnt_nxt - 16'(H_ACT_START) : 16'(H_ACTIVE);
      LineCount   <= (v_ph == PH_ACTIVE) ? vcnt_nxt - 16'(V_ACT_START) : 16'(V_ACTIVE);
      de_raw      <= (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
      hs_raw      <= (h_ph == PH_SYNC);
      vs_raw      <= (v_ph == PH_SYNC);
      line_start  <= (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE) &&
                     (hcnt_nxt == 16'(H_ACT_START));
      frame_start <= (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE) &&
                     (hcnt_nxt == 16'(H_ACT_START)) && (vcnt_nxt == 16'(V_ACT_START));
    end
  end

  // Control bits are kept active-high in the delay so a cleared line is idle.
  sync_delay_line #(.WIDTH(3), .DEPTH(PIPE_LAT), .RESET_VAL(3'b000)) u_ctrl_delay (
    .clk   (PixelClk),
    .rst_n (nRST),
    .d     ({de_raw, hs_raw, vs_raw}),
    .q     (ctrl_del)
  );

`ifdef LCD_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [2:0]  bar_idx;
  logic [15:0] bar_raw, bar_del;

  // Bar colour from the current coordinate; blanking maps to black
  always_comb begin
    bar_idx = 3'd7;
    if (PixelCount < 16'(H_ACTIVE)) bar_idx = 3'(PixelCount / 16'(BAR_W));
    bar_raw = bar_color(bar_idx);
  end

  sync_delay_line #(.WIDTH(16), .DEPTH(PIPE_LAT), .RESET_VAL(16'h0000)) u_bar_delay (
    .clk   (PixelClk),
    .rst_n (nRST),
    .d     (bar_raw),
    .q     (bar_del)
  );

  assign pix = bar_del;
`else
  assign pix = {rgb_in_R, rgb_in_G, rgb_in_B};
`endif

  // Panel output register: syncs are active-low, colour forced black outside DE
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      LCD_DEN   <= 1'b0;
      LCD_HSYNC <= 1'b1;
      LCD_VSYNC <= 1'b1;
      LCD_R     <= '0;
      LCD_G     <= '0;
      LCD_B     <= '0;
    end else begin
      LCD_DEN   <= ctrl_del[2];
      LCD_HSYNC <= ~ctrl_del[1];
      LCD_VSYNC <= ~ctrl_del[0];
      if (ctrl_del[2]) {LCD_R, LCD_G, LCD_B} <= pix;
      else             {LCD_R, LCD_G, LCD_B} <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen with small timing: H 2/3/8/2 (total 15),
// V 1/1/4/1 (total 7), PIPE_LAT=3, so one frame is 105 cycles and panel
// signals trail the coordinates by 4 cycles.
module tb_lcd_timing_gen;

  localparam int HT = 15;
  localparam int VT = 7;
  localparam int HA_START = 5;
  localparam int VA_START = 2;
  localparam int LAT = 3;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  // ---------------- clock / reset ----------------
  logic PixelClk = 1'b0;
  logic nRST     = 1'b0;
  always #5 PixelClk = ~PixelClk;

  lcd_timing_gen_if bus();

  lcd_timing_gen #(
    .H_SYNC(2), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .PIPE_LAT(LAT)
  ) dut (
    .PixelClk    (PixelClk),
    .nRST        (nRST),
    .PixelCount  (bus.pixel_count),
    .LineCount   (bus.line_count),
    .line_start  (bus.line_start),
    .frame_start (bus.frame_start),
    .rgb_in_R    (bus.rgb_r),
    .rgb_in_G    (bus.rgb_g),
    .rgb_in_B    (bus.rgb_b),
    .LCD_DEN     (bus.den),
    .LCD_HSYNC   (bus.hsync),
    .LCD_VSYNC   (bus.vsync),
    .LCD_R       (bus.r),
    .LCD_G       (bus.g),
    .LCD_B       (bus.b)
  );

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;
  int mcyc, rcyc, last_fs, ls_since, last_hs_fall, den_len;
  logic prev_hs;
  logic [15:0] pc_h [LAT+1];
  logic [15:0] lc_h [LAT+1];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
  endtask

  // ---------------- reference timing (cycle t after release) ----------------
  function automatic int m_h(input int t); return t % HT; endfunction
  function automatic int m_v(input int t); return (t / HT) % VT; endfunction
  function automatic bit m_hact(input int t);
    return m_h(t) >= HA_START && m_h(t) < HA_START + 8;
  endfunction
  function automatic bit m_vact(input int t);
    return m_v(t) >= VA_START && m_v(t) < VA_START + 4;
  endfunction
  function automatic bit m_de(input int t);
    return t >= 0 && m_hact(t) && m_vact(t);
  endfunction
  function automatic bit m_hs(input int t); return t >= 0 && m_h(t) < 2; endfunction
  function automatic bit m_vs(input int t); return t >= 0 && m_v(t) < 1; endfunction
  function automatic int m_pc(input int t); return m_hact(t) ? m_h(t) - HA_START : 8; endfunction
  function automatic int m_lc(input int t); return m_vact(t) ? m_v(t) - VA_START : 4; endfunction

  // Renderer colour for (x,y); e.g. (0,0) -> {1,2,31} = 16'h085F
  function automatic logic [15:0] render(input int x, input int y);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = 5'(x + 3 * y + 1);
    g = 6'(5 * x + 7 * y + 2);
    b = 5'(31 - x - y);
    return {r, g, b};
  endfunction

  function automatic logic [15:0] expected_pixel(input int x, input int y);
`ifdef LCD_TEST_PATTERN_EN
    // Bar width is 8/8 = 1 pixel here, so bar index equals x.
    return BARS[x];
`else
    return render(x, y);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_run();
    nRST = 1'b1;
    mcyc = 0;
    rcyc = 0;
    last_fs = -1;
    last_hs_fall = -1;
    ls_since = 0;
    den_len = 0;
    prev_hs = 1'b1;
    for (int i = 0; i <= LAT; i++) begin
      pc_h[i] = 16'd8;
      lc_h[i] = 16'd4;
    end
    mon_en = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel_count"}, int'(bus.pixel_count), 8);
    check({tag, "_line_count"}, int'(bus.line_count), 4);
    check({tag, "_line_start"}, int'(bus.line_start), 0);
    check({tag, "_frame_start"}, int'(bus.frame_start), 0);
    check({tag, "_den"}, int'(bus.den), 0);
    check({tag, "_hsync"}, int'(bus.hsync), 1);
    check({tag, "_vsync"}, int'(bus.vsync), 1);
    check({tag, "_rgb"}, int'({bus.r, bus.g, bus.b}), 0);
  endtask

  // ---------------- renderer: drives rgb_in, pushes expected colours ----------------
  initial begin
    bus.rgb_r = '0;
    bus.rgb_g = '0;
    bus.rgb_b = '0;
    forever begin
      @(negedge PixelClk);
      if (mon_en) begin
        for (int i = LAT; i > 0; i--) begin
          pc_h[i] = pc_h[i-1];
          lc_h[i] = lc_h[i-1];
        end
        pc_h[0] = bus.pixel_count;
        lc_h[0] = bus.line_count;
        {bus.rgb_r, bus.rgb_g, bus.rgb_b} = render(int'(pc_h[LAT]), int'(lc_h[LAT]));
        if (m_de(rcyc)) exp_q.push_back(expected_pixel(m_pc(rcyc), m_lc(rcyc)));
        rcyc++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int t;
    forever begin
      @(negedge PixelClk);
      if (mon_en) begin
        t = mcyc;
        check("pixel_count", int'(bus.pixel_count), m_pc(t));
        check("line_count", int'(bus.line_count), m_lc(t));
        check("line_start", int'(bus.line_start), int'(m_de(t) && m_pc(t) == 0));
        check("frame_start", int'(bus.frame_start),
              int'(m_de(t) && m_pc(t) == 0 && m_lc(t) == 0));
        check("den", int'(bus.den), int'(m_de(t - LAT - 1)));
        check("hsync", int'(bus.hsync), int'(!m_hs(t - LAT - 1)));
        check("vsync", int'(bus.vsync), int'(!m_vs(t - LAT - 1)));
        if (bus.den) begin
          check("rgb_queue_level", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0)
            check("rgb", int'({bus.r, bus.g, bus.b}), int'(exp_q.pop_front()));
          den_len++;
        end else begin
          check("rgb_blank", int'({bus.r, bus.g, bus.b}), 0);
          if (den_len > 0) check("den_per_line", den_len, 8);
          den_len = 0;
        end
        if (bus.frame_start) begin
          if (last_fs < 0) check("first_frame_start_t", t, 35);
          else begin
            check("frame_period", t - last_fs, 105);
            check("line_starts_per_frame", ls_since, 4);
          end
          last_fs = t;
          ls_since = 0;
        end
        if (bus.line_start) ls_since++;
        if (prev_hs && !bus.hsync) begin
          if (last_hs_fall < 0) check("first_hsync_fall_t", t, LAT + 1);
          else check("hsync_period", t - last_hs_fall, HT);
          last_hs_fall = t;
        end
        prev_hs = bus.hsync;
        mcyc++;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    repeat (3) @(posedge PixelClk);
    @(negedge PixelClk);
    #1;
    check_reset_outputs("reset");

    // Run 1: two full frames from release
    start_run();
    repeat (210) @(negedge PixelClk);

    // Reset mid active line at PixelCount=5
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge PixelClk);
      if (bus.pixel_count == 16'd5 && bus.den) found = 1'b1;
    end
    check("wait_mid_line", int'(found), 1);
    #2;
    nRST = 1'b0;
    mon_en = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    repeat (2) @(posedge PixelClk);
    @(negedge PixelClk);
    #1;
    check_reset_outputs("held_reset");

    // Run 2: timing after mid-frame reset must match run 1 exactly
    start_run();
    repeat (210) @(negedge PixelClk);
    #1;
    mon_en = 1'b0;
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Timing master for the 800x480 RGB565 LCD panel.
- Generates the PixelCount/LineCount coordinates that all overlay renderers consume (clock face, alarm-hourly display and others).
- Takes the merged renderer colour back in, aligns it to HSYNC/VSYNC/DE across the renderer pipeline latency, and drives the panel pins.

Parameters:
H_SYNC, 1, HSYNC pulse width (pixels)
H_BP, 182, horizontal back porch
H_ACTIVE, 800, active pixels per line
H_FP, 210, horizontal front porch
V_SYNC, 5, VSYNC pulse width (lines)
V_BP, 0, vertical back porch
V_ACTIVE, 480, active lines
V_FP, 45, vertical front porch
PIPE_LAT, 1, renderer latency in PixelClk cycles (range 0..7) from coordinates to rgb_in

Ports:
PixelClk  in  1  pixel clock
nRST  in  1  reset; asynchronous, active-low
PixelCount  out  16  active-area x coordinate; H_ACTIVE during horizontal blanking
LineCount  out  16  active-area y coordinate; V_ACTIVE during vertical blanking
line_start  out  1  one-cycle pulse, first active pixel of each active line
frame_start  out  1  one-cycle pulse, first active pixel of line 0
rgb_in_R  in  5  merged renderer red
rgb_in_G  in  6  merged renderer green
rgb_in_B  in  5  merged renderer blue
LCD_DEN  out  1  data enable
LCD_HSYNC  out  1  horizontal sync, active-low
LCD_VSYNC  out  1  vertical sync, active-low
LCD_R  out  5  panel red
LCD_G  out  6  panel green
LCD_B  out  5  panel blue

Behaviour:
Counters and totals
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP, default 1193.
- V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP, default 530.
- hcnt runs 0..H_TOTAL-1 and wraps to 0.
- vcnt increments on the hcnt wrap and itself wraps V_TOTAL-1 -> 0.

Phase sequence (each of h and v)
- SYNC -> BP -> ACTIVE -> FP -> SYNC.
- Boundaries:
  - SYNC: [0, SYNC)
  - BP: [SYNC, SYNC+BP)
  - ACTIVE: [SYNC+BP, SYNC+BP+ACTIVE)
  - FP: the remainder
- A zero-length phase (e.g. V_BP=0) is skipped with no idle cycle.

Registered outputs, same cycle as the counter state
- PixelCount = hcnt-(H_SYNC+H_BP) in h-ACTIVE, else H_ACTIVE.
- LineCount = vcnt-(V_SYNC+V_BP) in v-ACTIVE, else V_ACTIVE.
- de_raw = h-ACTIVE AND v-ACTIVE.
- hs_raw = h-SYNC.
- vs_raw = v-SYNC, aligned to the hcnt=0 boundary.
- line_start = de_raw AND PixelCount==0.
- frame_start = line_start AND LineCount==0.

Alignment
- {de_raw, hs_raw, vs_raw} pass through a PIPE_LAT-stage delay, then one output register.
- So LCD_DEN/HSYNC/VSYNC lag the coordinates by exactly PIPE_LAT+1 cycles.
- LCD_R/G/B are registered in the same cycle as LCD_DEN.
- LCD_R/G/B = rgb_in when the delayed DE is 1, else all zeros (black in blanking, never undriven).

Reset (async assert)
- hcnt=0, vcnt=0, delay line cleared.
- PixelCount=H_ACTIVE, LineCount=V_ACTIVE.
- line_start=0, frame_start=0.
- LCD_DEN=0, LCD_HSYNC=1, LCD_VSYNC=1, LCD_R/G/B=0.

After nRST release
- The first PixelClk edge registers hcnt=0, vcnt=0, i.e. frame starts in SYNC.
- Synchronous release is the system's responsibility.
- Reset mid-line/mid-frame: immediate return to reset values; no partial pulse is completed.

Boundary timing
- Last active pixel: PixelCount=H_ACTIVE-1; next cycle H_ACTIVE.
- Line wrap and frame wrap are single-cycle transitions with no gap.
- Exactly one frame_start per V_TOTAL*H_TOTAL cycles.

Optional Feature:
LCD_TEST_PATTERN_EN
- Defined: rgb_in is ignored. Panel shows 8 vertical colour bars indexed by PixelCount[15:0]/(H_ACTIVE/8):
  - white, yellow, cyan, green, magenta, red, blue, black (full-scale components)
  - The bar value is generated at coordinate time and passed through the same PIPE_LAT delay, so alignment is identical.
- Undefined: normal rgb_in pass-through. No extra logic.

Decomposition:
- Package lcd_timing_pkg holds:
  - default 800x480 timing constants
  - colour constants COLOR_WHITE/COLOR_BLACK/COLOR_RED (16-bit {R,G,B})
  - the 8 test-bar colours
- Renderers import the same constants for their background colour.
- One sub-module: sync_delay_line, a parameterised WIDTH x DEPTH shift register with async reset to a parameter value. DEPTH=0 is a wire.
- Used for the 3 control bits, and for the 16-bit bar colour when the feature is enabled.

Test Plan:
1. Small params H 2/3/8/2, V 1/1/4/1, PIPE_LAT=0: hold reset, then release -> first cycle hcnt=0, LCD_HSYNC=0 after 1 cycle, PixelCount=8; PixelCount 0..7 on cycles 5..12; H_TOTAL=15 verified by HSYNC period.
2. Same params -> LineCount 0..3 only on vcnt 2..5, else 4; frame_start exactly every 105 cycles; line_start exactly 4 per frame.
3. PIPE_LAT=3, rgb_in driven as a function of PixelCount registered 3 times -> LCD_R/G/B on every DEN cycle equal the expected colour for coordinate (x,y); LCD_R/G/B=0 whenever LCD_DEN=0.
4. Assert nRST mid-active line at PixelCount=5 -> same-cycle LCD_DEN=0, HSYNC=VSYNC=1, PixelCount=8; after release, identical timing to scenario 1.
5. Default 800x480 params -> HSYNC period 1193, VSYNC low for 5*1193 cycles, 800 DEN cycles per active line, 480 active lines per frame.
6. LCD_TEST_PATTERN_EN defined, default params -> PixelCount 0..99 yields 16'hFFFF; PixelCount 700..799 yields 16'h0000; rgb_in toggling has no effect.
